// File: rtl/bird_motion.sv
// bird_motion: vertical physics and IDLE/PLAY/DEAD game-state FSM for the bird.
// Position and velocity update once per frame_tick. A flap seen during a frame
// is remembered until that frame's tick. Score counts pipe-pass pulses while playing.
module bird_motion #(
  parameter int Y_W      = 10,
  parameter int V_W      = 6,
  parameter int SCORE_W  = 8,
  parameter int SCREEN_H = 480,
  parameter int BIRD_H   = 16,
  parameter int START_Y  = 232,
  parameter int GRAVITY  = 1,
  parameter int FLAP_V   = 8,
  parameter int MAX_FALL = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flap,
  input  logic               frame_tick,
  input  logic               hit,
  input  logic               pipe_passed,
  output logic [Y_W-1:0]     bird_y,
  output logic [V_W-1:0]     bird_vel,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    DEAD   = 2'd2,
    UNUSED = 2'd3
  } state_t;

  localparam logic [Y_W-1:0]        START_POS = Y_W'(START_Y);
  localparam logic signed [Y_W+1:0] FLOOR_Y   = (Y_W+2)'(SCREEN_H - BIRD_H);
  localparam logic signed [V_W-1:0] FLAP_VEL  = V_W'(-FLAP_V);
  localparam logic signed [V_W:0]   GRAV_INC  = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]   FALL_MAX  = (V_W+1)'(MAX_FALL);
  localparam logic [SCORE_W-1:0]    SCORE_TOP = {SCORE_W{1'b1}};

  state_t               state_q, state_d;
  logic                 flap_pend, pend_d;
  logic [Y_W-1:0]       y_d;
  logic [V_W-1:0]       vel_d;
  logic [SCORE_W-1:0]   score_d;
  logic                 over_d;

  logic                 flap_now;
  logic signed [V_W:0]  vel_inc;
  logic signed [V_W-1:0] vel_new;
  logic signed [Y_W+1:0] y_new;

  // Candidate physics step: flap overrides gravity; position is widened so it cannot wrap.
  always_comb begin
    flap_now = flap_pend | flap;
    vel_inc  = $signed({bird_vel[V_W-1], bird_vel}) + GRAV_INC;
    if (flap_now)
      vel_new = FLAP_VEL;
    else if (vel_inc > FALL_MAX)
      vel_new = FALL_MAX[V_W-1:0];
    else
      vel_new = vel_inc[V_W-1:0];
    y_new = $signed({2'b00, bird_y}) + (Y_W+2)'(vel_new);
  end

  // Next-state and next-register values for the game FSM.
  always_comb begin
    state_d = state_q;
    pend_d  = flap_pend;
    y_d     = bird_y;
    vel_d   = bird_vel;
    score_d = score;
    over_d  = game_over;
    case (state_q)
      IDLE: begin
        y_d    = START_POS;
        vel_d  = '0;
        pend_d = 1'b0;
        over_d = 1'b0;
        if (flap) begin
          state_d = PLAY;
          score_d = '0;
          pend_d  = 1'b1;
        end
      end
      PLAY: begin
        over_d = 1'b0;
        if (pipe_passed && score != SCORE_TOP)
          score_d = score + 1'b1;
        if (hit) begin
          state_d = DEAD;
          over_d  = 1'b1;
          pend_d  = 1'b0;
        end else if (frame_tick) begin
          pend_d = 1'b0;
          if (y_new < 0) begin
            y_d   = '0;
            vel_d = '0;
          end else if (y_new >= FLOOR_Y) begin
            y_d     = FLOOR_Y[Y_W-1:0];
            vel_d   = '0;
            state_d = DEAD;
            over_d  = 1'b1;
          end else begin
            y_d   = y_new[Y_W-1:0];
            vel_d = vel_new;
          end
        end else if (flap) begin
          pend_d = 1'b1;
        end
      end
      DEAD: begin
        over_d = 1'b1;
        pend_d = 1'b0;
        if (flap) begin
          state_d = IDLE;
          y_d     = START_POS;
          vel_d   = '0;
          over_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        y_d     = START_POS;
        vel_d   = '0;
        score_d = '0;
        pend_d  = 1'b0;
        over_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bird_y    <= START_POS;
      bird_vel  <= '0;
      score     <= '0;
      game_over <= 1'b0;
      flap_pend <= 1'b0;
    end else begin
      state_q   <= state_d;
      bird_y    <= y_d;
      bird_vel  <= vel_d;
      score     <= score_d;
      game_over <= over_d;
      flap_pend <= pend_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_bird_motion.sv
// tb_bird_motion: directed scenarios for bird_motion with hand-computed expectations.
module tb_bird_motion;

  logic       clk;
  logic       rst;
  logic       flap;
  logic       frame_tick;
  logic       hit;
  logic       pipe_passed;
  logic [9:0] bird_y;
  logic [5:0] bird_vel;
  logic [1:0] state;
  logic [7:0] score;
  logic       game_over;

  wire signed [5:0] vel_s = bird_vel;

  int tests_run = 0;
  int fails = 0;

  bird_motion dut (
    .clk(clk),
    .rst(rst),
    .flap(flap),
    .frame_tick(frame_tick),
    .hit(hit),
    .pipe_passed(pipe_passed),
    .bird_y(bird_y),
    .bird_vel(bird_vel),
    .state(state),
    .score(score),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given inputs applied; returns 1 time unit after the edge.
  task automatic step(input logic f, input logic ft, input logic h, input logic pp);
    @(negedge clk);
    flap = f; frame_tick = ft; hit = h; pipe_passed = pp;
    @(posedge clk);
    #1;
    flap = 1'b0; frame_tick = 1'b0; hit = 1'b0; pipe_passed = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (state !== 2'd0 || bird_y !== 10'd232 || bird_vel !== 6'd0 || score !== 8'd0 || game_over !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset: state=%0d y=%0d vel=%0d score=%0d go=%0b, want 0 232 0 0 0",
               state, bird_y, vel_s, score, game_over);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (state !== 2'd0 || bird_y !== 10'd232 || score !== 8'd0) begin
      fails++;
      $display("[TB] FAIL idle_ignore: state=%0d y=%0d score=%0d, want 0 232 0", state, bird_y, score);
    end
  endtask

  task automatic test_start();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (state !== 2'd1 || bird_y !== 10'd232 || bird_vel !== 6'd0) begin
      fails++;
      $display("[TB] FAIL start: state=%0d y=%0d vel=%0d, want 1 232 0", state, bird_y, vel_s);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bird_y !== 10'd224 || vel_s !== -6'sd8) begin
      fails++;
      $display("[TB] FAIL first_tick: y=%0d vel=%0d, want 224 -8", bird_y, vel_s);
    end
  endtask

  // Continues from y=224 vel=-8: twenty free-fall frames, velocity saturating at 10.
  task automatic test_gravity();
    int ey, ev;
    ey = 224; ev = -8;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ev = (ev + 1 > 10) ? 10 : ev + 1;
      ey = ey + ev;
      tests_run++;
      if (bird_y !== 10'(ey) || vel_s !== 6'(ev)) begin
        fails++;
        $display("[TB] FAIL gravity[%0d]: y=%0d vel=%0d, want %0d %0d", i, bird_y, vel_s, ey, ev);
      end
    end
    tests_run++;
    if (ey != 271 || state !== 2'd1) begin
      fails++;
      $display("[TB] FAIL gravity_end: y=%0d state=%0d, want 271 1", bird_y, state);
    end
  endtask

  // Continues from y=271 vel=10.
  task automatic test_flap_merge();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bird_y !== 10'd263 || vel_s !== -6'sd8) begin
      fails++;
      $display("[TB] FAIL flap_same_tick: y=%0d vel=%0d, want 263 -8", bird_y, vel_s);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (bird_y !== 10'd263 || vel_s !== -6'sd8) begin
      fails++;
      $display("[TB] FAIL flap_no_tick: y=%0d vel=%0d, want 263 -8", bird_y, vel_s);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bird_y !== 10'd255 || vel_s !== -6'sd8) begin
      fails++;
      $display("[TB] FAIL double_flap: y=%0d vel=%0d, want 255 -8", bird_y, vel_s);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bird_y !== 10'd248 || vel_s !== -6'sd7) begin
      fails++;
      $display("[TB] FAIL pend_cleared: y=%0d vel=%0d, want 248 -7", bird_y, vel_s);
    end
  endtask

  // Continues from y=248 vel=-7; falls until the floor kills the bird.
  task automatic test_floor();
    int ey, ev, es;
    bit done;
    ey = 248; ev = -7; es = 1; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ev = (ev + 1 > 10) ? 10 : ev + 1;
      ey = ey + ev;
      if (ey >= 464) begin
        ey = 464; ev = 0; es = 2; done = 1'b1;
      end
      tests_run++;
      if (bird_y !== 10'(ey) || vel_s !== 6'(ev) || state !== 2'(es)) begin
        fails++;
        $display("[TB] FAIL fall[%0d]: y=%0d vel=%0d state=%0d, want %0d %0d %0d",
                 i, bird_y, vel_s, state, ey, ev, es);
      end
    end
    tests_run++;
    if (!done || game_over !== 1'b1) begin
      fails++;
      $display("[TB] FAIL floor_dead: done=%0b go=%0b, want 1 1", done, game_over);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (bird_y !== 10'd464 || state !== 2'd2 || score !== 8'd0) begin
      fails++;
      $display("[TB] FAIL dead_frozen: y=%0d state=%0d score=%0d, want 464 2 0", bird_y, state, score);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (state !== 2'd0 || bird_y !== 10'd232 || bird_vel !== 6'd0 || game_over !== 1'b0) begin
      fails++;
      $display("[TB] FAIL dead_to_idle: state=%0d y=%0d vel=%0d go=%0b, want 0 232 0 0",
               state, bird_y, vel_s, game_over);
    end
  endtask

  task automatic test_hit_score();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (score !== 8'd3) begin
      fails++;
      $display("[TB] FAIL score3: score=%0d, want 3", score);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (state !== 2'd2 || bird_y !== 10'd224 || vel_s !== -6'sd8 || score !== 8'd4 || game_over !== 1'b1) begin
      fails++;
      $display("[TB] FAIL hit_tick: state=%0d y=%0d vel=%0d score=%0d go=%0b, want 2 224 -8 4 1",
               state, bird_y, vel_s, score, game_over);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (state !== 2'd0 || score !== 8'd4) begin
      fails++;
      $display("[TB] FAIL score_kept: state=%0d score=%0d, want 0 4", state, score);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (state !== 2'd1 || score !== 8'd0) begin
      fails++;
      $display("[TB] FAIL score_clear: state=%0d score=%0d, want 1 0", state, score);
    end
    for (int i = 0; i < 256; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (score !== 8'd255) begin
      fails++;
      $display("[TB] FAIL score_sat: score=%0d, want 255", score);
    end
  endtask

  // From a fresh game: flap every frame up into the ceiling, then drift and flap again.
  task automatic test_ceiling();
    int ey, ev;
    bit f;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ey = 232; ev = 0;
    for (int i = 0; i < 34; i++) begin
      f = (i < 31) || (i == 33);
      step(f, 1'b1, 1'b0, 1'b0);
      ev = f ? -8 : ((ev + 1 > 10) ? 10 : ev + 1);
      ey = ey + ev;
      if (ey < 0) begin
        ey = 0; ev = 0;
      end
      tests_run++;
      if (bird_y !== 10'(ey) || vel_s !== 6'(ev)) begin
        fails++;
        $display("[TB] FAIL ceiling[%0d]: y=%0d vel=%0d, want %0d %0d", i, bird_y, vel_s, ey, ev);
      end
    end
    tests_run++;
    if (state !== 2'd1 || game_over !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ceiling_alive: state=%0d go=%0b, want 1 0", state, game_over);
    end
  endtask

  task automatic test_rst_mid();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    tests_run++;
    if (state !== 2'd0 || bird_y !== 10'd232 || bird_vel !== 6'd0 || score !== 8'd0 || game_over !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_mid: state=%0d y=%0d vel=%0d score=%0d go=%0b, want 0 232 0 0 0",
               state, bird_y, vel_s, score, game_over);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (state !== 2'd0 || bird_y !== 10'd232) begin
      fails++;
      $display("[TB] FAIL rst_no_pend: state=%0d y=%0d, want 0 232", state, bird_y);
    end
  endtask

  initial begin
    rst = 1'b1;
    flap = 1'b0;
    frame_tick = 1'b0;
    hit = 1'b0;
    pipe_passed = 1'b0;
    test_reset();
    test_start();
    test_gravity();
    test_flap_merge();
    test_floor();
    test_hit_score();
    test_ceiling();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
